// File: rtl/branch_redirect_ctrl_pkg.sv
// rtl/branch_redirect_ctrl_pkg.sv - shared encodings for branch detection and redirect control
package branch_redirect_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REDIRECT = 2'b01,
        ST_SQUASH   = 2'b10
    } redirect_state_t;

    localparam logic [3:0] OP_BRANCH      = 4'b1100;
    localparam logic [3:0] OP_BRANCH_LINK = 4'b1101;

    typedef enum logic [2:0] {
        COND_EQ     = 3'b000,
        COND_NE     = 3'b001,
        COND_LT     = 3'b010,
        COND_GE     = 3'b011,
        COND_LTU    = 3'b100,
        COND_GEU    = 3'b101,
        COND_ALWAYS = 3'b110,
        COND_NEVER  = 3'b111
    } branch_cond_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// rtl/branch_redirect_ctrl_sat_counter.sv - saturating up-counter with async clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc_en && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - turns EX branch-taken requests into PC redirect and squash
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              take_branch,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              mem_stall,
    input  logic              halt,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_redirect,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              redirect_busy,
    output logic [CNT_W-1:0]  branch_count
);

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES - 1);

    redirect_state_t   state, state_n;
    logic [2:0]        sq_cnt, sq_cnt_n;
    logic [ADDR_W-1:0] redirect_n;
    logic              pc_sel_n, flush_if_id_n, flush_id_ex_n, busy_n;
    logic              accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            sq_cnt        <= '0;
            pc_redirect   <= '0;
            pc_sel        <= 1'b0;
            flush_if_id   <= 1'b0;
            flush_id_ex   <= 1'b0;
            redirect_busy <= 1'b0;
        end else begin
            state         <= state_n;
            sq_cnt        <= sq_cnt_n;
            pc_redirect   <= redirect_n;
            pc_sel        <= pc_sel_n;
            flush_if_id   <= flush_if_id_n;
            flush_id_ex   <= flush_id_ex_n;
            redirect_busy <= busy_n;
        end
    end

    // Halt wins over stall; a stall freezes everything, including a pending accept.
    always_comb begin
        state_n       = state;
        sq_cnt_n      = sq_cnt;
        redirect_n    = pc_redirect;
        pc_sel_n      = pc_sel;
        flush_if_id_n = flush_if_id;
        flush_id_ex_n = flush_id_ex;
        busy_n        = redirect_busy;
        accept        = 1'b0;
        if (halt) begin
            state_n       = ST_IDLE;
            sq_cnt_n      = '0;
            pc_sel_n      = 1'b0;
            flush_if_id_n = 1'b0;
            flush_id_ex_n = 1'b0;
            busy_n        = 1'b0;
        end else if (!mem_stall) begin
            case (state)
                ST_IDLE: begin
                    if (take_branch) begin
                        accept        = 1'b1;
                        state_n       = ST_REDIRECT;
                        redirect_n    = branch_target;
                        pc_sel_n      = 1'b1;
                        flush_if_id_n = 1'b1;
                        flush_id_ex_n = 1'b1;
                        busy_n        = 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    pc_sel_n      = 1'b0;
                    flush_id_ex_n = 1'b0;
                    if (SQUASH_CYCLES == 1) begin
                        state_n       = ST_IDLE;
                        flush_if_id_n = 1'b0;
                        busy_n        = 1'b0;
                    end else begin
                        state_n  = ST_SQUASH;
                        sq_cnt_n = SQ_LOAD;
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt == 3'd1) begin
                        state_n       = ST_IDLE;
                        sq_cnt_n      = '0;
                        flush_if_id_n = 1'b0;
                        busy_n        = 1'b0;
                    end else begin
                        sq_cnt_n = sq_cnt - 3'd1;
                    end
                end
                default: begin
                    state_n       = ST_IDLE;
                    sq_cnt_n      = '0;
                    pc_sel_n      = 1'b0;
                    flush_if_id_n = 1'b0;
                    flush_id_ex_n = 1'b0;
                    busy_n        = 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_branch_count (
        .clk    (clk),
        .rst    (rst),
        .inc_en (accept),
        .count  (branch_count)
    );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        take0 = 0, stall0 = 0, halt0 = 0;
    logic [15:0] tgt0 = 0;
    logic        sel0, fif0, fie0, busy0;
    logic [15:0] red0, cnt0;

    logic        take1 = 0, stall1 = 0, halt1 = 0;
    logic [15:0] tgt1 = 0;
    logic        sel1, fif1, fie1, busy1;
    logic [15:0] red1;
    logic [3:0]  cnt1;

    branch_redirect_ctrl #(.ADDR_W(16), .SQUASH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .take_branch(take0), .branch_target(tgt0),
        .mem_stall(stall0), .halt(halt0), .pc_sel(sel0), .pc_redirect(red0),
        .flush_if_id(fif0), .flush_id_ex(fie0), .redirect_busy(busy0),
        .branch_count(cnt0)
    );

    branch_redirect_ctrl #(.ADDR_W(16), .SQUASH_CYCLES(1), .CNT_W(4)) dut_sq1 (
        .clk(clk), .rst(rst), .take_branch(take1), .branch_target(tgt1),
        .mem_stall(stall1), .halt(halt1), .pc_sel(sel1), .pc_redirect(red1),
        .flush_if_id(fif1), .flush_id_ex(fie1), .redirect_busy(busy1),
        .branch_count(cnt1)
    );

    typedef struct {
        logic        which;
        int          id;
        logic [35:0] outs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    function automatic logic [35:0] pack_outs(input logic s, input logic [15:0] r,
                                              input logic fi, input logic fe,
                                              input logic b, input logic [15:0] c);
        return {s, r, fi, fe, b, c};
    endfunction

    task automatic step(input logic w, input logic tk, input logic [15:0] tg,
                        input logic st, input logic ht,
                        input logic e_sel, input logic [15:0] e_red, input logic e_fif,
                        input logic e_fie, input logic e_busy, input logic [15:0] e_cnt);
        exp_t e;
        @(negedge clk);
        if (!w) begin
            take0 = tk; tgt0 = tg; stall0 = st; halt0 = ht;
        end else begin
            take1 = tk; tgt1 = tg; stall1 = st; halt1 = ht;
        end
        e.which = w;
        e.id    = vec_id;
        e.outs  = pack_outs(e_sel, e_red, e_fif, e_fie, e_busy, e_cnt);
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: compares the registered outputs after each edge against the queued expectation.
    initial begin
        exp_t        e;
        logic [35:0] got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!e.which) got = pack_outs(sel0, red0, fif0, fie0, busy0, cnt0);
                else          got = pack_outs(sel1, red1, fif1, fie1, busy1, {12'd0, cnt1});
                tests++;
                if (got !== e.outs) begin
                    fails++;
                    $display("FAIL vec%0d dut%0d got=%h exp=%h", e.id, e.which, got, e.outs);
                end
            end
        end
    end

    task automatic check_zero(input int tag);
        logic [35:0] g0, g1;
        g0 = pack_outs(sel0, red0, fif0, fie0, busy0, cnt0);
        g1 = pack_outs(sel1, red1, fif1, fie1, busy1, {12'd0, cnt1});
        tests++;
        if (g0 !== 36'd0 || g1 !== 36'd0) begin
            fails++;
            $display("FAIL reset_zero%0d got=%h/%h exp=0", tag, g0, g1);
        end
    endtask

    initial begin
        logic [15:0] c;
        #1;
        check_zero(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 16'd0);

        // single branch and wrong-path requests
        step(0, 1, 16'h0040, 0, 0, 1, 16'h0040, 1, 1, 1, 16'd1);
        step(0, 1, 16'h0080, 0, 0, 0, 16'h0040, 1, 0, 1, 16'd1);
        step(0, 1, 16'h0080, 0, 0, 0, 16'h0040, 0, 0, 0, 16'd1);
        step(0, 0, 16'h0000, 0, 0, 0, 16'h0040, 0, 0, 0, 16'd1);

        // stall held in REDIRECT
        step(0, 1, 16'h0100, 0, 0, 1, 16'h0100, 1, 1, 1, 16'd2);
        for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1, 0, 1, 16'h0100, 1, 1, 1, 16'd2);
        step(0, 0, 16'h0000, 0, 0, 0, 16'h0100, 1, 0, 1, 16'd2);
        step(0, 0, 16'h0000, 0, 0, 0, 16'h0100, 0, 0, 0, 16'd2);

        // take_branch blocked by stall in IDLE
        step(0, 1, 16'h0200, 1, 0, 0, 16'h0100, 0, 0, 0, 16'd2);
        step(0, 1, 16'h0200, 1, 0, 0, 16'h0100, 0, 0, 0, 16'd2);
        step(0, 1, 16'h0200, 0, 0, 1, 16'h0200, 1, 1, 1, 16'd3);

        // halt in REDIRECT, then halt (with stall) in SQUASH, then halt blocking accept
        step(0, 0, 16'h0000, 0, 1, 0, 16'h0200, 0, 0, 0, 16'd3);
        step(0, 1, 16'h0300, 0, 0, 1, 16'h0300, 1, 1, 1, 16'd4);
        step(0, 0, 16'h0000, 0, 0, 0, 16'h0300, 1, 0, 1, 16'd4);
        step(0, 1, 16'h0400, 1, 1, 0, 16'h0300, 0, 0, 0, 16'd4);
        step(0, 1, 16'h0400, 0, 1, 0, 16'h0300, 0, 0, 0, 16'd4);
        step(0, 1, 16'h0400, 0, 0, 1, 16'h0400, 1, 1, 1, 16'd5);

        // async reset in the middle of REDIRECT, between edges
        @(posedge clk);
        #4;
        take0 = 0; stall0 = 0; halt0 = 0;
        rst = 1'b1;
        #1;
        check_zero(1);
        @(negedge clk);
        rst = 1'b0;

        // SQUASH_CYCLES=1 instance: one-cycle flush, wrong-path ignore, 4-bit saturation
        for (int i = 0; i < 20; i++) begin
            c = (i + 1 > 15) ? 16'd15 : 16'(i + 1);
            step(1, 1, 16'(16'h1000 + i), 0, 0, 1, 16'(16'h1000 + i), 1, 1, 1, c);
            step(1, 1, 16'hFFFF, 0, 0, 0, 16'(16'h1000 + i), 0, 0, 0, c);
        end

        repeat (2) @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d exp=0 pending", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
